// File: rtl/mem_access_stage_if.sv
// Bundle of EXE-side, data-memory and writeback signals around the memory access stage.
// The stage itself connects through the slave modport; its environment uses master.
interface mem_access_stage_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
);
  logic             ex_valid;
  logic             ex_ready;
  logic [DSIZE-1:0] ex_aluout;
  logic [DSIZE-1:0] ex_sdata;
  logic [ASIZE-1:0] ex_waddr;
  logic             ex_wen;
  logic             ex_memrd;
  logic             ex_memwr;

  logic             dmem_req;
  logic             dmem_we;
  logic [DSIZE-1:0] dmem_addr;
  logic [DSIZE-1:0] dmem_wdata;
  logic [DSIZE-1:0] dmem_rdata;
  logic             dmem_ack;

  logic             wb_valid;
  logic             wb_wen;
  logic [ASIZE-1:0] wb_waddr;
  logic [DSIZE-1:0] wb_wdata;
  logic             mem_err;

  modport master (
    output ex_valid, ex_aluout, ex_sdata, ex_waddr, ex_wen, ex_memrd, ex_memwr,
    output dmem_rdata, dmem_ack,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_wen, wb_waddr, wb_wdata, mem_err
  );

  modport slave (
    input  ex_valid, ex_aluout, ex_sdata, ex_waddr, ex_wen, ex_memrd, ex_memwr,
    input  dmem_rdata, dmem_ack,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_wen, wb_waddr, wb_wdata, mem_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// EXE->MEM->WB stage: ALU results go to writeback after one register; loads/stores run a
// req/ack transaction on the data port, stalling EXE until ack or timeout.
module mem_access_stage #(
  parameter int DSIZE   = 32,
  parameter int ASIZE   = 5,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  mem_access_stage_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [ASIZE-1:0] lat_waddr_p1;
  logic             lat_wen_p1;
  logic             accept, is_mem, ack_hit, tmo_hit;

  // The all-ones register address is the hardwired zero register and is never written.
  function automatic logic gate_wen(input logic wen, input logic [ASIZE-1:0] waddr);
    return wen && (waddr != {ASIZE{1'b1}});
  endfunction

  assign bus.ex_ready = (state == S_IDLE);

  always_comb begin
    accept    = bus.ex_valid && (state == S_IDLE);
    is_mem    = bus.ex_memrd || bus.ex_memwr;
    ack_hit   = (state == S_WAIT) && bus.dmem_ack;
    tmo_hit   = (state == S_WAIT) && !bus.dmem_ack && (cnt == CW'(TIMEOUT - 1));
    state_nxt = state;
    if (accept && is_mem)    state_nxt = S_WAIT;
    if (ack_hit || tmo_hit)  state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Counts WAIT cycles that passed without an ack; cleared whenever the transaction ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cnt <= '0;
    else if (state == S_WAIT && state_nxt == S_WAIT)  cnt <= cnt + 1'b1;
    else                                              cnt <= '0;
  end

  // Stage boundary p0 -> p1: memory request and writeback bundle registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      lat_waddr_p1   <= '0;
      lat_wen_p1     <= 1'b0;
      bus.wb_valid   <= 1'b0;
      bus.wb_wen     <= 1'b0;
      bus.wb_waddr   <= '0;
      bus.wb_wdata   <= '0;
      bus.mem_err    <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.wb_wen   <= 1'b0;
      if (accept && !is_mem) begin
        bus.wb_valid <= 1'b1;
        bus.wb_wen   <= gate_wen(bus.ex_wen, bus.ex_waddr);
        bus.wb_waddr <= bus.ex_waddr;
        bus.wb_wdata <= bus.ex_aluout;
      end
      if (accept && is_mem) begin
        bus.dmem_req   <= 1'b1;
        bus.dmem_we    <= !bus.ex_memrd;
        bus.dmem_addr  <= bus.ex_aluout;
        bus.dmem_wdata <= bus.ex_sdata;
        lat_waddr_p1   <= bus.ex_waddr;
        lat_wen_p1     <= bus.ex_wen;
      end
      if (ack_hit) begin
        bus.dmem_req <= 1'b0;
        bus.wb_valid <= 1'b1;
        bus.wb_waddr <= lat_waddr_p1;
        bus.wb_wen   <= !bus.dmem_we && gate_wen(lat_wen_p1, lat_waddr_p1);
        bus.wb_wdata <= bus.dmem_we ? '0 : bus.dmem_rdata;
      end else if (tmo_hit) begin
        bus.dmem_req <= 1'b0;
        bus.mem_err  <= 1'b1;
        bus.wb_valid <= 1'b1;
        bus.wb_waddr <= lat_waddr_p1;
        bus.wb_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized traffic, all compared each
// cycle against a transaction-level model of the stage.
module tb_mem_access_stage;
  localparam int DSIZE   = 32;
  localparam int ASIZE   = 5;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_stage_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  mem_access_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  int ack_delay = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level picture of the stage: either free, or holding one outstanding memory op
  typedef struct packed {
    logic        busy;
    logic        is_load;
    logic [4:0]  waddr;
    logic        wen;
    logic [7:0]  age;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        err;
    logic        tmo;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_next(input mdl_t s);
    mdl_t n;
    n = s;
    n.wb_valid = 1'b0;
    n.wb_wen   = 1'b0;
    n.tmo      = 1'b0;
    if (!s.busy) begin
      if (bus.ex_valid) begin
        if (bus.ex_memrd || bus.ex_memwr) begin
          n.busy = 1'b1; n.is_load = bus.ex_memrd; n.waddr = bus.ex_waddr; n.wen = bus.ex_wen;
          n.age = 8'd0; n.req = 1'b1; n.we = !bus.ex_memrd;
          n.addr = bus.ex_aluout; n.wdata = bus.ex_sdata;
        end else begin
          n.wb_valid = 1'b1; n.wb_waddr = bus.ex_waddr; n.wb_wdata = bus.ex_aluout;
          n.wb_wen = bus.ex_wen && (bus.ex_waddr != 5'd31);
        end
      end
    end else begin
      n.age = s.age + 8'd1;
      if (bus.dmem_ack) begin
        n.busy = 1'b0; n.req = 1'b0; n.wb_valid = 1'b1; n.wb_waddr = s.waddr;
        n.wb_wdata = s.is_load ? bus.dmem_rdata : 32'h0;
        n.wb_wen = s.is_load && s.wen && (s.waddr != 5'd31);
      end else if (n.age == 8'(TIMEOUT)) begin
        n.busy = 1'b0; n.req = 1'b0; n.err = 1'b1; n.wb_valid = 1'b1; n.tmo = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ex_ready", bus.ex_ready, m.busy ? 32'd0 : 32'd1);
      check("dmem_req", bus.dmem_req, m.req);
      if (m.req) begin
        check("dmem_we", bus.dmem_we, m.we);
        check("dmem_addr", bus.dmem_addr, m.addr);
        check("dmem_wdata", bus.dmem_wdata, m.wdata);
      end
      check("wb_valid", bus.wb_valid, m.wb_valid);
      check("wb_wen", bus.wb_wen, m.wb_wen);
      check("mem_err", bus.mem_err, m.err);
      if (m.wb_valid && !m.tmo) begin
        check("wb_waddr", bus.wb_waddr, m.wb_waddr);
        check("wb_wdata", bus.wb_wdata, m.wb_wdata);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] wa, input logic wen, input logic rd, input logic wr);
    bus.ex_valid = v; bus.ex_aluout = alu; bus.ex_sdata = sd; bus.ex_waddr = wa;
    bus.ex_wen = wen; bus.ex_memrd = rd; bus.ex_memwr = wr;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    tick(); tick();
    check("rst_req", bus.dmem_req, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_mem_err", bus.mem_err, 0);
    check("rst_ready", bus.ex_ready, 1);
    check("rst_wb_wdata", bus.wb_wdata, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Three back-to-back ALU ops, with a stray ack that must be ignored
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_0000;
    drive(1, 32'h10, 0, 1, 1, 0, 0); tick();
    check("t2_v1", bus.wb_valid, 1); check("t2_d1", bus.wb_wdata, 32'h10);
    check("t2_a1", bus.wb_waddr, 1); check("t2_r1", bus.ex_ready, 1);
    drive(1, 32'h20, 0, 2, 1, 0, 0); tick();
    check("t2_v2", bus.wb_valid, 1); check("t2_d2", bus.wb_wdata, 32'h20);
    check("t2_a2", bus.wb_waddr, 2); check("t2_r2", bus.ex_ready, 1);
    drive(1, 32'h30, 0, 3, 1, 0, 0); tick();
    check("t2_v3", bus.wb_valid, 1); check("t2_d3", bus.wb_wdata, 32'h30);
    check("t2_a3", bus.wb_waddr, 3); check("t2_w3", bus.wb_wen, 1);
    bus.dmem_ack = 1'b0;

    // Load with ack on the third WAIT cycle
    drive(1, 32'h40, 0, 5, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t3_req1", bus.dmem_req, 1); check("t3_addr1", bus.dmem_addr, 32'h40);
    check("t3_we", bus.dmem_we, 0); check("t3_rdy1", bus.ex_ready, 0);
    tick();
    check("t3_req2", bus.dmem_req, 1); check("t3_addr2", bus.dmem_addr, 32'h40);
    check("t3_rdy2", bus.ex_ready, 0);
    tick();
    check("t3_req3", bus.dmem_req, 1); check("t3_rdy3", bus.ex_ready, 0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
    tick();
    bus.dmem_ack = 1'b0;
    check("t3_wbv", bus.wb_valid, 1); check("t3_wbd", bus.wb_wdata, 32'hDEADBEEF);
    check("t3_wen", bus.wb_wen, 1); check("t3_wba", bus.wb_waddr, 5);
    check("t3_req_off", bus.dmem_req, 0); check("t3_rdy", bus.ex_ready, 1);

    // Store acked on the first WAIT cycle
    drive(1, 32'h44, 32'h1234, 7, 1, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t4_req", bus.dmem_req, 1); check("t4_we", bus.dmem_we, 1);
    check("t4_wdata", bus.dmem_wdata, 32'h1234); check("t4_addr", bus.dmem_addr, 32'h44);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_AAAA;
    tick();
    bus.dmem_ack = 1'b0;
    check("t4_wbv", bus.wb_valid, 1); check("t4_wen", bus.wb_wen, 0);
    check("t4_wbd", bus.wb_wdata, 0); check("t4_req_off", bus.dmem_req, 0);

    // Zero-register write suppression, and load with memrd=memwr=1
    drive(1, 32'h55, 0, 31, 1, 0, 0); tick();
    check("t6_wbv", bus.wb_valid, 1); check("t6_wen", bus.wb_wen, 0);
    check("t6_wba", bus.wb_waddr, 31);
    drive(1, 32'h60, 32'h99, 9, 1, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t6_req", bus.dmem_req, 1); check("t6_we", bus.dmem_we, 0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFE;
    tick();
    bus.dmem_ack = 1'b0;
    check("t6_ld_wen", bus.wb_wen, 1); check("t6_ld_d", bus.wb_wdata, 32'hCAFE);

    // Ack on the last allowed WAIT cycle beats the timeout
    drive(1, 32'h80, 0, 6, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      check("t5v_req", bus.dmem_req, 1);
      if (i == TIMEOUT) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111; end
      tick();
    end
    bus.dmem_ack = 1'b0;
    check("t5v_wbv", bus.wb_valid, 1); check("t5v_wen", bus.wb_wen, 1);
    check("t5v_wbd", bus.wb_wdata, 32'h1111); check("t5v_err", bus.mem_err, 0);

    // Timeout with no ack
    drive(1, 32'h84, 0, 6, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      check("t5_req", bus.dmem_req, 1);
      tick();
    end
    check("t5_req_off", bus.dmem_req, 0); check("t5_err", bus.mem_err, 1);
    check("t5_wbv", bus.wb_valid, 1); check("t5_wen", bus.wb_wen, 0);
    check("t5_rdy", bus.ex_ready, 1);
    drive(1, 32'h77, 0, 4, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t5_next_v", bus.wb_valid, 1); check("t5_next_d", bus.wb_wdata, 32'h77);
    check("t5_err_sticky", bus.mem_err, 1);

    // Asynchronous reset in the middle of a WAIT
    drive(1, 32'h90, 0, 8, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t1_req", bus.dmem_req, 1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("t1_req_off", bus.dmem_req, 0); check("t1_wbv", bus.wb_valid, 0);
    check("t1_err", bus.mem_err, 0); check("t1_rdy", bus.ex_ready, 1);
    tick();
    rst = 1'b0;
    drive(1, 32'hAB, 0, 3, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t1_alu_v", bus.wb_valid, 1); check("t1_alu_d", bus.wb_wdata, 32'hAB);
    check("t1_alu_err", bus.mem_err, 0);

    // Randomized traffic; ack timing chosen per memory op, some delays past the timeout
    for (int c = 0; c < 4000; c++) begin
      int kind;
      logic [1:0] rw;
      kind = $urandom_range(0, 9);
      rw = 2'($urandom_range(1, 3));
      if (kind < 6)
        drive($urandom_range(0, 9) < 8, $urandom, $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 0, 0);
      else
        drive($urandom_range(0, 9) < 8, $urandom, $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), rw[0], rw[1]);
      if (!m.busy) ack_delay = $urandom_range(0, 17);
      bus.dmem_rdata = $urandom;
      if (m.busy) bus.dmem_ack = (int'(m.age) == ack_delay);
      else        bus.dmem_ack = ($urandom_range(0, 4) == 0);
      tick();
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    bus.dmem_ack = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
